// File: rtl/paint_scan_driver.sv
// paint_scan_driver: raster scan master driving painter coordinates and streaming captured colours to the LCD writer.
// Optional SCAN_TESTPAT_EN adds a test_mode input that substitutes 8 vertical colour bars.
module paint_scan_driver #(
  parameter int X_RES      = 480,
  parameter int Y_RES      = 800,
  parameter int LEAD       = 5,
  parameter int PIPE_LAT   = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               frame_start,
  output logic               busy,
  output logic               frame_done,
  output logic signed [15:0] paint_x,
  output logic signed [15:0] paint_y,
  input  logic        [15:0] paint_color,
  output logic        [15:0] pix_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_first,
  output logic               pix_last
`ifdef SCAN_TESTPAT_EN
  ,
  input  logic               test_mode
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  typedef struct packed {
    logic [15:0] data;
    logic        first;
    logic        last;
  } entry_t;
  state_t               state_q, state_d;
  logic [15:0]          tx_q, tx_d, ty_q, ty_d;
  logic signed [15:0]   px_q, px_d, py_q, py_d;
  logic [PIPE_LAT-1:0]  v_q, v_d, f_q, f_d, l_q, l_d;
  entry_t               mem_q [FIFO_DEPTH];
  entry_t               mem_d [FIFO_DEPTH];
  entry_t               head;
  logic [AW-1:0]        rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic                 issue, push, pop, eol, last_xy;
  logic [15:0]          cap_data;
`ifdef SCAN_TESTPAT_EN
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [PIPE_LAT-1:0]      tm_q, tm_d;
  logic [PIPE_LAT-1:0][2:0] bar_q, bar_d;
  // test_mode and the bar index ride alongside the valid bit so they match the captured pixel
  always_comb begin
    tm_d     = {tm_q[PIPE_LAT-2:0], test_mode};
    bar_d    = {bar_q[PIPE_LAT-2:0], 3'(int'(tx_q) * 8 / X_RES)};
    cap_data = tm_q[PIPE_LAT-1] ? BARS[bar_q[PIPE_LAT-1]] : paint_color;
  end
  always_ff @(posedge clk) begin
    tm_q  <= !rstn ? '0 : tm_d;
    bar_q <= !rstn ? '0 : bar_d;
  end
`else
  assign cap_data = paint_color;
`endif
  assign head      = mem_q[rd_q];
  assign pix_valid = cnt_q != '0;
  assign pix_data  = head.data;
  assign pix_first = head.first;
  assign pix_last  = head.last;
  assign paint_x   = px_q;
  assign paint_y   = py_q;
  assign busy      = state_q != IDLE;
  always_comb begin
    eol        = tx_q == 16'(X_RES - 1);
    last_xy    = eol && ty_q == 16'(Y_RES - 1);
    // credit counts both buffered and in-flight pixels, so the FIFO can never overflow
    issue      = state_q == ISSUE && int'(cnt_q) + $countones(v_q) < FIFO_DEPTH;
    push       = v_q[PIPE_LAT-1];
    pop        = pix_valid && pix_ready;
    frame_done = pop && head.last && state_q == DRAIN;
    state_d    = state_q == IDLE  ? (frame_start ? ISSUE : IDLE) :
                 state_q == ISSUE ? (issue && last_xy ? DRAIN : ISSUE) :
                                    (frame_done ? IDLE : DRAIN);
    tx_d       = issue ? (eol ? '0 : tx_q + 16'd1) : tx_q;
    ty_d       = issue && eol ? (last_xy ? '0 : ty_q + 16'd1) : ty_q;
    px_d       = issue ? 16'(int'(tx_q) - LEAD) : px_q;
    py_d       = issue ? 16'(int'(ty_q) - LEAD) : py_q;
    v_d        = {v_q[PIPE_LAT-2:0], issue};
    f_d        = {f_q[PIPE_LAT-2:0], issue && tx_q == '0 && ty_q == '0};
    l_d        = {l_q[PIPE_LAT-2:0], issue && last_xy};
    mem_d      = mem_q;
    if (push)
      mem_d[wr_q] = '{data: cap_data, first: f_q[PIPE_LAT-1], last: l_q[PIPE_LAT-1]};
    wr_d       = wr_q + AW'(push);
    rd_d       = rd_q + AW'(pop);
    cnt_d      = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      tx_q    <= '0;
      ty_q    <= '0;
      px_q    <= 16'(-LEAD);
      py_q    <= 16'(-LEAD);
      v_q     <= '0;
      f_q     <= '0;
      l_q     <= '0;
      mem_q   <= '{default: '0};
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      px_q    <= px_d;
      py_q    <= py_d;
      v_q     <= v_d;
      f_q     <= f_d;
      l_q     <= l_d;
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && !pop && int'(cnt_q) == FIFO_DEPTH));
endmodule

// File: tb/tb_paint_scan_driver.sv
// tb_paint_scan_driver: directed frames on a reduced 40x6 raster with a painter model and a pixel scoreboard.
// The painter model registers colour from paint_x/paint_y through PIPE_LAT-1 stages, so with the coordinate register it spans PIPE_LAT clocks from the issue decision.
module tb_paint_scan_driver;
  localparam int X = 40, Y = 6, N = X * Y, LEAD = 5, PL = 5;
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic clk = 0, rstn = 0, frame_start = 0, pix_ready = 0;
  logic busy, frame_done, pix_valid, pix_first, pix_last;
  logic signed [15:0] paint_x, paint_y;
  logic [15:0] paint_color, pix_data;
  logic [15:0] pp [PL-1];
  logic tm_exp = 0, rnd = 0, mon_hs;
  int n_chk = 0, n_fail = 0, hs_cnt = 0, base = 0, mon_n, lat, s;
`ifdef SCAN_TESTPAT_EN
  logic test_mode = 0;
`endif
  paint_scan_driver #(.X_RES(X), .Y_RES(Y), .LEAD(LEAD), .PIPE_LAT(PL), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
    .paint_x(paint_x), .paint_y(paint_y), .paint_color(paint_color), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_first(pix_first), .pix_last(pix_last)
`ifdef SCAN_TESTPAT_EN
    , .test_mode(test_mode)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    pp[0] <= {8'(int'(paint_y) + LEAD), 8'(int'(paint_x) + LEAD)};
    for (int i = 1; i < PL - 1; i++) pp[i] <= pp[i-1];
  end
  assign paint_color = pp[PL-2];
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (pixel %0d)", tag, got, exp, hs_cnt - base);
    end
  endtask
  function automatic int exp_color(input int n);
    int x = n % X, y = n / X;
    return tm_exp ? int'(BARS[x * 8 / X]) : ((y % 256) << 8) | (x % 256);
  endfunction
  // scoreboard: every handshake must be the next raster pixel
  always @(negedge clk) if (rstn) begin
    mon_n  = hs_cnt - base;
    mon_hs = pix_valid && pix_ready;
    check("frame_done", int'(frame_done), int'(mon_hs && mon_n == N - 1));
    if (mon_hs) begin
      check("pix_data", int'(pix_data), exp_color(mon_n));
      check("pix_first", int'(pix_first), int'(mon_n == 0));
      check("pix_last", int'(pix_last), int'(mon_n == N - 1));
      hs_cnt++;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_frame();
    base = hs_cnt;
    frame_start = 1;
    tick();
    frame_start = 0;
  endtask
  task automatic wait_px(input int target, input int bound);
    int c = 0;
    while (hs_cnt - base < target && c < bound) begin
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    if (c >= bound) check("timeout", hs_cnt - base, target);
  endtask
  initial begin
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(pix_valid), 0);
    check("rst_data", int'(pix_data), 0);
    check("rst_first", int'(pix_first), 0);
    check("rst_last", int'(pix_last), 0);
    check("rst_paint_x", int'(paint_x), -LEAD);
    check("rst_paint_y", int'(paint_y), -LEAD);
    rstn = 1;
    tick();
    check("idle_done", int'(frame_done), 0);
    // frame 1: ready held high, latency and first coordinates
    pix_ready = 1;
    start_frame();
    check("busy_start", int'(busy), 1);
    tick();
    check("issue0_x", int'(paint_x), -5);
    check("issue0_y", int'(paint_y), -5);
    tick();
    check("issue1_x", int'(paint_x), -4);
    lat = 2;
    while (!pix_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("first_latency", lat, PL + 1);
    check("first_data", int'(pix_data), 0);
    wait_px(100, 500);
    frame_start = 1;
    tick();
    frame_start = 0;
    check("busy_mid", int'(busy), 1);
    wait_px(N, 1000);
    check("busy_end", int'(busy), 0);
    repeat (10) tick();
    check("restart_ignored", int'(busy), 0);
    check("idle_valid", int'(pix_valid), 0);
    // frame 2: long stall mid-line, credit must cap issue at 8 pixels past the last pop
    start_frame();
    wait_px(50, 500);
    pix_ready = 0;
    s = hs_cnt - base;
    repeat (100) tick();
    check("stall_pops", hs_cnt - base, s);
    check("stall_valid", int'(pix_valid), 1);
    check("stall_x", int'(paint_x), (s + 7) % X - LEAD);
    check("stall_y", int'(paint_y), (s + 7) / X - LEAD);
    pix_ready = 1;
    wait_px(N, 1000);
    check("busy_end2", int'(busy), 0);
    // frame 3: random backpressure
    rnd = 1;
    start_frame();
    wait_px(N, 5000);
    rnd = 0;
    pix_ready = 1;
    check("busy_end3", int'(busy), 0);
    // frame 4: reset mid-frame then a clean frame from (0,0)
    start_frame();
    wait_px(100, 500);
    rstn = 0;
    tick();
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(pix_valid), 0);
    check("abort_paint_x", int'(paint_x), -LEAD);
    check("abort_data", int'(pix_data), 0);
    rstn = 1;
    tick();
    start_frame();
    wait_px(N, 1000);
    check("busy_end4", int'(busy), 0);
`ifdef SCAN_TESTPAT_EN
    test_mode = 1;
    tm_exp = 1;
    start_frame();
    wait_px(N, 1000);
    test_mode = 0;
    tm_exp = 0;
    check("busy_end5", int'(busy), 0);
`endif
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
